// File: rtl/song_pkg.sv
// Shared types and default constants for the song sequencer.
// Consumed by song_play_ctrl and beat_divider.
package song_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] NOTE_REST = 4'd0;

  localparam int STEPS  = 64;
  localparam int STEP_W = 6;
  localparam int DIV_W  = 24;

  localparam int DIV0 = 1250000;
  localparam int DIV1 = 1000000;
  localparam int DIV2 = 833333;
  localparam int DIV3 = 625000;

endpackage

// File: rtl/beat_divider.sv
// Beat tick generator; tempo is latched only at a beat boundary
// or while cleared, so a tempo change never cuts a beat short.
module beat_divider #(
  parameter int DIV_W = song_pkg::DIV_W,
  parameter int DIV0  = song_pkg::DIV0,
  parameter int DIV1  = song_pkg::DIV1,
  parameter int DIV2  = song_pkg::DIV2,
  parameter int DIV3  = song_pkg::DIV3
) (
  input  logic       clk_5m,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] tempo,
  output logic       tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] lim;
  logic [DIV_W-1:0] lim_sel;

  always_comb begin
    lim_sel = DIV_W'(DIV0 - 1);
    unique case (tempo)
      2'd0: lim_sel = DIV_W'(DIV0 - 1);
      2'd1: lim_sel = DIV_W'(DIV1 - 1);
      2'd2: lim_sel = DIV_W'(DIV2 - 1);
      2'd3: lim_sel = DIV_W'(DIV3 - 1);
    endcase
  end

  assign tick = en && !clr && (cnt == lim);

  always_ff @(posedge clk_5m) begin
    if (rst) begin
      cnt <= '0;
      lim <= DIV_W'(DIV0 - 1);
    end else if (clr || tick) begin
      cnt <= '0;
      lim <= lim_sel;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/song_play_ctrl.sv
// Play/pause/stop sequencer with keyboard-over-autoplay arbitration.
// Define SONG_LOOP_EN to loop the song instead of stopping at its end.
module song_play_ctrl #(
  parameter int STEPS  = song_pkg::STEPS,
  parameter int STEP_W = song_pkg::STEP_W,
  parameter int DIV_W  = song_pkg::DIV_W,
  parameter int DIV0   = song_pkg::DIV0,
  parameter int DIV1   = song_pkg::DIV1,
  parameter int DIV2   = song_pkg::DIV2,
  parameter int DIV3   = song_pkg::DIV3
) (
  input  logic              clk_5m,
  input  logic              rst,
  input  logic              play_btn,
  input  logic              stop_btn,
  input  logic [1:0]        func,
  input  logic [1:0]        tempo,
  input  logic              key_valid,
  input  logic [3:0]        key_med,
  input  logic [3:0]        key_low,
  input  logic [3:0]        rom_med_ma,
  input  logic [3:0]        rom_low_ma,
  input  logic [3:0]        rom_med_ch,
  input  logic [3:0]        rom_low_ch,
  output logic [STEP_W-1:0] step,
  output logic [1:0]        song_sel,
  output logic              beat,
  output logic              playing,
  output logic [3:0]        med_ma,
  output logic [3:0]        low_ma,
  output logic [3:0]        med_ch,
  output logic [3:0]        low_ch
);
  import song_pkg::*;

  state_t              state;
  state_t              next;
  logic                tick;
  logic                en;
  logic                clr;
  logic                last;
  logic [STEP_W-1:0]   step_nx;
  logic [1:0]          song_nx;

  // pause freezes the divider on the very cycle it is requested
  assign en   = (state == PLAY) && !play_btn;
  assign clr  = stop_btn || (state == IDLE);
  assign last = (step == STEP_W'(STEPS - 1));

  beat_divider #(
    .DIV_W (DIV_W),
    .DIV0  (DIV0),
    .DIV1  (DIV1),
    .DIV2  (DIV2),
    .DIV3  (DIV3)
  ) u_div (
    .clk_5m (clk_5m),
    .rst    (rst),
    .en     (en),
    .clr    (clr),
    .tempo  (tempo),
    .tick   (tick)
  );

  always_comb begin
    next    = state;
    step_nx = step;
    song_nx = song_sel;
    if (stop_btn) begin
      next    = IDLE;
      step_nx = '0;
    end else begin
      unique case (state)
        IDLE: if (play_btn) begin
          next    = PLAY;
          step_nx = '0;
          song_nx = func;
        end
        PLAY: if (play_btn) begin
          next = PAUSE;
        end else if (tick) begin
          if (last) begin
            step_nx = '0;
`ifdef SONG_LOOP_EN
            next = PLAY;
`else
            next = IDLE;
`endif
          end else begin
            step_nx = step + 1'b1;
          end
        end
        PAUSE: if (play_btn) next = PLAY;
        default: next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_5m) begin
    if (rst) begin
      state    <= IDLE;
      step     <= '0;
      song_sel <= '0;
      beat     <= 1'b0;
      playing  <= 1'b0;
      med_ma   <= NOTE_REST;
      low_ma   <= NOTE_REST;
      med_ch   <= NOTE_REST;
      low_ch   <= NOTE_REST;
    end else begin
      state    <= next;
      step     <= step_nx;
      song_sel <= song_nx;
      beat     <= tick;
      playing  <= (next == PLAY);
      med_ch   <= (state == PLAY) ? rom_med_ch : NOTE_REST;
      low_ch   <= (state == PLAY) ? rom_low_ch : NOTE_REST;
      if (key_valid) begin
        med_ma <= key_med;
        low_ma <= key_low;
      end else begin
        med_ma <= (state == PLAY) ? rom_med_ma : NOTE_REST;
        low_ma <= (state == PLAY) ? rom_low_ma : NOTE_REST;
      end
    end
  end

endmodule

// File: tb/tb_song_play_ctrl.sv
// Directed bench for song_play_ctrl with a cycle-level behavioural
// model; STEPS=8 and beat lengths 4/5/6/8 cycles.
module tb_song_play_ctrl;

  logic       clk;
  logic       rst;
  logic       play_btn;
  logic       stop_btn;
  logic [1:0] func;
  logic [1:0] tempo;
  logic       key_valid;
  logic [3:0] key_med;
  logic [3:0] key_low;
  logic [3:0] rom_med_ma;
  logic [3:0] rom_low_ma;
  logic [3:0] rom_med_ch;
  logic [3:0] rom_low_ch;
  logic [2:0] step;
  logic [1:0] song_sel;
  logic       beat;
  logic       playing;
  logic [3:0] med_ma;
  logic [3:0] low_ma;
  logic [3:0] med_ch;
  logic [3:0] low_ch;

  song_play_ctrl #(
    .STEPS(8), .STEP_W(3), .DIV_W(24),
    .DIV0(4), .DIV1(5), .DIV2(6), .DIV3(8)
  ) dut (
    .clk_5m(clk), .rst(rst),
    .play_btn(play_btn), .stop_btn(stop_btn),
    .func(func), .tempo(tempo),
    .key_valid(key_valid), .key_med(key_med), .key_low(key_low),
    .rom_med_ma(rom_med_ma), .rom_low_ma(rom_low_ma),
    .rom_med_ch(rom_med_ch), .rom_low_ch(rom_low_ch),
    .step(step), .song_sel(song_sel), .beat(beat), .playing(playing),
    .med_ma(med_ma), .low_ma(low_ma), .med_ch(med_ch), .low_ch(low_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] f_med_ma(input int s, input int k);
    return 4'((k + 1 + 4 * s) & 15);
  endfunction
  function automatic logic [3:0] f_low_ma(input int s, input int k);
    return 4'((2 * k + s) & 15);
  endfunction
  function automatic logic [3:0] f_med_ch(input int s, input int k);
    return 4'((k + 15 + 3 * s) & 15);
  endfunction
  function automatic logic [3:0] f_low_ch(input int s, input int k);
    return 4'((15 - k - s) & 15);
  endfunction

  assign rom_med_ma = f_med_ma(int'(song_sel), int'(step));
  assign rom_low_ma = f_low_ma(int'(song_sel), int'(step));
  assign rom_med_ch = f_med_ch(int'(song_sel), int'(step));
  assign rom_low_ch = f_low_ch(int'(song_sel), int'(step));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
  endtask

  // model: 0 idle, 1 play, 2 pause
  int  divs [4] = '{4, 5, 6, 8};
  bit  m_valid = 0;
  int  m_st, m_step, m_song, m_pos, m_len;
  int  o_st, o_step, o_song;
  bit  m_tk;
  int  e_beat, e_play, e_med_ma, e_low_ma, e_med_ch, e_low_ch;
  int  a_ma, a_lo;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_st = 0; m_step = 0; m_song = 0; m_pos = 0; m_len = 4;
      e_beat = 0; e_play = 0;
      e_med_ma = 0; e_low_ma = 0; e_med_ch = 0; e_low_ch = 0;
    end else begin
      o_st = m_st; o_step = m_step; o_song = m_song; m_tk = 0;
      if (stop_btn) begin
        m_st = 0; m_step = 0; m_pos = 0; m_len = divs[tempo];
      end else if (m_st == 0) begin
        m_pos = 0; m_len = divs[tempo];
        if (play_btn) begin m_st = 1; m_step = 0; m_song = int'(func); end
      end else if (m_st == 1 && play_btn) begin
        m_st = 2;
      end else if (m_st == 1) begin
        if (m_pos == m_len - 1) begin
          m_tk = 1; m_pos = 0; m_len = divs[tempo];
          if (m_step == 7) begin
            m_step = 0;
`ifndef SONG_LOOP_EN
            m_st = 0;
`endif
          end else m_step++;
        end else m_pos++;
      end else if (m_st == 2 && play_btn) begin
        m_st = 1;
      end
      e_beat = int'(m_tk);
      e_play = (m_st == 1) ? 1 : 0;
      e_med_ch = (o_st == 1) ? int'(f_med_ch(o_song, o_step)) : 0;
      e_low_ch = (o_st == 1) ? int'(f_low_ch(o_song, o_step)) : 0;
      a_ma = (o_st == 1) ? int'(f_med_ma(o_song, o_step)) : 0;
      a_lo = (o_st == 1) ? int'(f_low_ma(o_song, o_step)) : 0;
      e_med_ma = key_valid ? int'(key_med) : a_ma;
      e_low_ma = key_valid ? int'(key_low) : a_lo;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_step", int'(step), m_step);
      chk("m_song_sel", int'(song_sel), m_song);
      chk("m_beat", int'(beat), e_beat);
      chk("m_playing", int'(playing), e_play);
      chk("m_med_ma", int'(med_ma), e_med_ma);
      chk("m_low_ma", int'(low_ma), e_low_ma);
      chk("m_med_ch", int'(med_ch), e_med_ch);
      chk("m_low_ch", int'(low_ch), e_low_ch);
    end
  end

  task automatic pulse_play();
    play_btn = 1'b1;
    @(negedge clk);
    play_btn = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_btn = 1'b1;
    @(negedge clk);
    stop_btn = 1'b0;
  endtask

  task automatic wait_beat(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (beat) return;
    end
    chk("beat_timeout", 0, 1);
    n = -1;
  endtask

  int n;
  int nb;

  initial begin
    rst = 1'b1; play_btn = 1'b0; stop_btn = 1'b0;
    func = 2'd0; tempo = 2'd0;
    key_valid = 1'b0; key_med = 4'd0; key_low = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_step", int'(step), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_med_ma", int'(med_ma), 0);

    pulse_play();
    chk("t1_playing", int'(playing), 1);
    repeat (3) @(negedge clk);
    chk("t1_nobeat", int'(beat), 0);
    @(negedge clk);
    chk("t1_beat1", int'(beat), 1);
    chk("t1_step1", int'(step), 1);
    @(negedge clk);
    chk("t1_med_ma_s1", int'(med_ma), 2);
    repeat (3) @(negedge clk);
    chk("t1_beat2", int'(beat), 1);
    chk("t1_step2", int'(step), 2);

    key_valid = 1'b1; key_med = 4'd5; key_low = 4'd9;
    @(negedge clk);
    chk("t4_key_med", int'(med_ma), 5);
    chk("t4_chord", int'(med_ch), 1);
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    chk("t4_release", int'(med_ma), 3);
    @(negedge clk);
    chk("t4_step3", int'(step), 3);

    repeat (2) @(negedge clk);
    pulse_play();
    chk("t2_paused", int'(playing), 0);
    repeat (20) @(negedge clk);
    chk("t2_step_frozen", int'(step), 3);
    chk("t2_rest_ma", int'(med_ma), 0);
    chk("t2_rest_ch", int'(med_ch), 0);
    pulse_play();
    chk("t2_resumed", int'(playing), 1);
    @(negedge clk);
    chk("t2_wait", int'(beat), 0);
    @(negedge clk);
    chk("t2_resume_beat", int'(beat), 1);
    chk("t2_step4", int'(step), 4);

    repeat (3) @(negedge clk);
    play_btn = 1'b1; stop_btn = 1'b1;
    @(negedge clk);
    play_btn = 1'b0; stop_btn = 1'b0;
    chk("t3_no_beat", int'(beat), 0);
    chk("t3_step0", int'(step), 0);
    chk("t3_idle", int'(playing), 0);
    repeat (3) @(negedge clk);
    chk("t3_rest", int'(med_ma), 0);

    func = 2'd0;
    pulse_play();
    func = 2'd2;
    repeat (3) @(negedge clk);
    chk("t5_song_held", int'(song_sel), 0);
    pulse_stop();
    pulse_play();
    chk("t5_song2", int'(song_sel), 2);
    @(negedge clk);
    tempo = 2'd3;
    wait_beat(n);
    chk("t5_cur_beat_len", n + 1, 4);
    wait_beat(n);
    chk("t5_next_beat_len", n, 8);
    tempo = 2'd0;

    repeat (5) wait_beat(n);
    chk("t6_step7", int'(step), 7);
    wait_beat(n);
    chk("t6_final_beat", int'(beat), 1);
    chk("t6_step_wrap", int'(step), 0);
`ifdef SONG_LOOP_EN
    chk("t6_still_play", int'(playing), 1);
    wait_beat(n);
    chk("t6_loop_len", n, 4);
    chk("t6_loop_step1", int'(step), 1);
`else
    chk("t6_idle", int'(playing), 0);
    nb = 0;
    repeat (10) begin
      @(negedge clk);
      nb += int'(beat);
    end
    chk("t6_single_beat", nb, 0);
    chk("t6_rest", int'(med_ma), 0);
`endif

    pulse_stop();
    pulse_play();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_beat", int'(beat), 0);
    chk("rst_mid_playing", int'(playing), 0);
    chk("rst_mid_step", int'(step), 0);
    chk("rst_mid_song", int'(song_sel), 0);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
